// File: rtl/wb_data_sel_pipe_if.sv
// Handshake bundle for the write-back selector: input beat (sources, select,
// extension, destination) with valid/ready, and the register-file side output.
interface wb_data_sel_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int N_SRC  = 4,
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]       sel;
  logic [1:0]             ext_mode;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   wr_en_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [ADDR_W-1:0]      out_addr;
  logic                   out_wr_en;
  logic                   err_sel;

  modport master (
    output in_valid, src_data, sel, ext_mode,
    output rd_addr, wr_en_in, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_addr, out_wr_en, err_sel
  );

  modport slave (
    input  in_valid, src_data, sel, ext_mode,
    input  rd_addr, wr_en_in, out_ready,
    output in_ready, out_valid, out_data,
    output out_addr, out_wr_en, err_sel
  );
endinterface

// File: rtl/wb_data_sel_pipe.sv
// Registered write-back data selector with load extension and 2-entry skid.
// Ports: clk, reset (async, active-high), bus (slave side of the handshake).
module wb_data_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int N_SRC  = 4,
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 5
) (
  input logic              clk,
  input logic              reset,
  wb_data_sel_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]  d, new_data;
  logic [WIDTH-1:0]  main_data, sk_data;
  logic [ADDR_W-1:0] main_addr, sk_addr;
  logic              main_wr, sk_wr, new_wr;
  logic              sel_ok, in_ready_q;
  logic              accept, xfer;
  logic              ld_main, ld_skid, mv_skid;

  // Out-of-range select yields zero data.
  always_comb begin
    d      = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        d      = bus.src_data[k*WIDTH +: WIDTH];
        sel_ok = 1'b1;
      end
    end
  end

  always_comb begin
    case (bus.ext_mode)
      2'b01:   new_data = {{(WIDTH-8){d[7]}}, d[7:0]};
      2'b10:   new_data = {{(WIDTH-16){d[15]}}, d[15:0]};
      2'b11:   new_data = {{(WIDTH-8){1'b0}}, d[7:0]};
      default: new_data = d;
    endcase
  end

  // x0 is hardwired; never write it.
  assign new_wr = bus.wr_en_in & (bus.rd_addr != '0);

  assign accept = bus.in_valid & in_ready_q;
  assign xfer   = (state != EMPTY) & bus.out_ready;

  always_comb begin
    state_nx = state;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    mv_skid  = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nx = ONE;
          ld_main  = 1'b1;
        end
      end
      ONE: begin
        if (accept && !xfer) begin
          state_nx = FULL;
          ld_skid  = 1'b1;
        end else if (accept) begin
          ld_main = 1'b1;
        end else if (xfer) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          state_nx = ONE;
          mv_skid  = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      bus.err_sel <= 1'b0;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != FULL);
      if (accept && !sel_ok) bus.err_sel <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data <= '0;
      main_addr <= '0;
      main_wr   <= 1'b0;
      sk_data   <= '0;
      sk_addr   <= '0;
      sk_wr     <= 1'b0;
    end else begin
      if (ld_main) begin
        main_data <= new_data;
        main_addr <= bus.rd_addr;
        main_wr   <= new_wr;
      end else if (mv_skid) begin
        main_data <= sk_data;
        main_addr <= sk_addr;
        main_wr   <= sk_wr;
      end
      if (ld_skid) begin
        sk_data <= new_data;
        sk_addr <= bus.rd_addr;
        sk_wr   <= new_wr;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_data;
  assign bus.out_addr  = main_addr;
  assign bus.out_wr_en = (state != EMPTY) & main_wr;

endmodule

// File: tb/tb_wb_data_sel_pipe.sv
// Bench for wb_data_sel_pipe: queue-based reference model checked every
// cycle, directed literal cases, then randomized valid/ready traffic.
module tb_wb_data_sel_pipe;

  localparam int W  = 32;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int AW = 5;

  typedef struct {
    logic [W-1:0]  d;
    logic [AW-1:0] a;
    logic          w;
  } beat_t;

  logic clk;
  logic reset;

  wb_data_sel_pipe_if #(
    .WIDTH(W), .N_SRC(NS), .SEL_W(SW), .ADDR_W(AW)
  ) bus ();

  wb_data_sel_pipe #(
    .WIDTH(W), .N_SRC(NS), .SEL_W(SW), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_acc  = 0;

  beat_t       q[$];
  logic        err_exp;
  logic [W-1:0]  last_d;
  logic [AW-1:0] last_a;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_data(
    input logic [NS*W-1:0] sd, input int s, input int e);
    logic [W-1:0] v;
    v = (s < NS) ? sd[s*W +: W] : '0;
    case (e)
      1: begin
        v = v % 256;
        if (v >= 128) v = v + 32'hFFFF_FF00;
      end
      2: begin
        v = v % 65536;
        if (v >= 32768) v = v + 32'hFFFF_0000;
      end
      3: v = v % 256;
      default: ;
    endcase
    return v;
  endfunction

  // Model: FIFO of up to two beats; reflects each edge at the prior negedge.
  always @(negedge clk) begin
    beat_t b;
    bit acc, xf;
    if (reset) begin
      q.delete();
      err_exp = 1'b0;
      last_d  = '0;
      last_a  = '0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_err_sel", 32'(bus.err_sel), 32'd0);
      chk("rst_out_wr_en", 32'(bus.out_wr_en), 32'd0);
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      chk("err_sel", 32'(bus.err_sel), 32'(err_exp));
      if (q.size() != 0) begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_addr", 32'(bus.out_addr), 32'(q[0].a));
        chk("out_wr_en", 32'(bus.out_wr_en), 32'(q[0].w));
      end else begin
        chk("hold_data", bus.out_data, last_d);
        chk("hold_addr", 32'(bus.out_addr), 32'(last_a));
        chk("idle_wr_en", 32'(bus.out_wr_en), 32'd0);
      end
      acc = bus.in_valid && (q.size() < 2);
      xf  = (q.size() != 0) && bus.out_ready;
      if (xf) begin
        last_d = q[0].d;
        last_a = q[0].a;
        void'(q.pop_front());
      end
      if (acc) begin
        b.d = model_data(bus.src_data, int'(bus.sel),
                         int'(bus.ext_mode));
        b.a = bus.rd_addr;
        b.w = bus.wr_en_in && (bus.rd_addr != 0);
        q.push_back(b);
        n_acc++;
        if (int'(bus.sel) >= NS) err_exp = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int s, input int e,
                       input int rd, input bit we);
    bus.in_valid = v;
    bus.sel      = SW'(s);
    bus.ext_mode = 2'(e);
    bus.rd_addr  = AW'(rd);
    bus.wr_en_in = we;
  endtask

  logic [31:0] ext_exp [4];
  int target;
  int guard;

  initial begin
    ext_exp[0] = 32'h0000_8F80;
    ext_exp[1] = 32'hFFFF_FF80;
    ext_exp[2] = 32'hFFFF_8F80;
    ext_exp[3] = 32'h0000_0080;

    reset         = 1'b1;
    bus.out_ready = 1'b1;
    bus.src_data  = '0;
    drive(0, 0, 0, 0, 0);
    repeat (3) cyc();
    @(negedge clk);
    chk("lit_rst_data", bus.out_data, 32'd0);
    chk("lit_rst_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    reset = 1'b0;

    // back-to-back throughput
    bus.src_data = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    cyc();
    drive(1, 1, 0, 4, 1);
    cyc();
    drive(1, 0, 0, 5, 1);
    @(negedge clk);
    chk("lit_b2b_first", bus.out_data, 32'hBBBB_BBBB);
    cyc();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_b2b_second", bus.out_data, 32'hAAAA_AAAA);
    chk("lit_b2b_valid", 32'(bus.out_valid), 32'd1);
    cyc();
    @(negedge clk);
    chk("lit_b2b_idle", 32'(bus.out_valid), 32'd0);

    // load extension
    bus.src_data = {32'hCCCC_CCCC, 32'h0000_8F80, 32'hAAAA_AAAA};
    for (int e = 0; e < 4; e++) begin
      cyc();
      drive(1, 1, e, 7, 1);
      cyc();
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("lit_ext%0d", e), bus.out_data, ext_exp[e]);
    end

    // stall with three beats offered
    bus.src_data = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    cyc();
    bus.out_ready = 1'b0;
    drive(1, 0, 0, 1, 1);
    cyc();
    drive(1, 1, 0, 2, 1);
    @(negedge clk);
    chk("lit_stall_rdy1", 32'(bus.in_ready), 32'd1);
    cyc();
    drive(1, 2, 0, 3, 1);
    @(negedge clk);
    chk("lit_stall_rdy0", 32'(bus.in_ready), 32'd0);
    chk("lit_stall_dA", bus.out_data, 32'hAAAA_AAAA);
    cyc();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("lit_stall_hold", bus.out_data, 32'hAAAA_AAAA);
    chk("lit_stall_addr", 32'(bus.out_addr), 32'd1);
    chk("lit_stall_rdy0b", 32'(bus.in_ready), 32'd0);
    cyc();
    @(negedge clk);
    chk("lit_stall_dB", bus.out_data, 32'hBBBB_BBBB);
    chk("lit_stall_rdy", 32'(bus.in_ready), 32'd1);
    cyc();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_stall_dC", bus.out_data, 32'hCCCC_CCCC);
    cyc();
    @(negedge clk);
    chk("lit_stall_done", 32'(bus.out_valid), 32'd0);

    // out-of-range select, write to x0
    cyc();
    drive(1, 3, 0, 0, 1);
    cyc();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_bad_data", bus.out_data, 32'd0);
    chk("lit_bad_err", 32'(bus.err_sel), 32'd1);
    chk("lit_x0_wr", 32'(bus.out_wr_en), 32'd0);
    repeat (2) cyc();
    @(negedge clk);
    chk("lit_err_sticky", 32'(bus.err_sel), 32'd1);

    // reset while FULL
    cyc();
    bus.out_ready = 1'b0;
    drive(1, 0, 0, 9, 1);
    cyc();
    drive(1, 1, 0, 10, 1);
    cyc();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_full_rdy", 32'(bus.in_ready), 32'd0);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("lit_full_rst_v", 32'(bus.out_valid), 32'd0);
    chk("lit_full_rst_r", 32'(bus.in_ready), 32'd1);
    chk("lit_full_rst_e", 32'(bus.err_sel), 32'd0);
    cyc();
    reset = 1'b0;

    // random traffic
    target = n_acc + 1000;
    guard  = 0;
    while (n_acc < target && guard < 20000) begin
      cyc();
      bus.src_data = {$urandom(), $urandom(), $urandom()};
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 31),
            $urandom_range(0, 1) == 1);
      bus.out_ready = $urandom_range(0, 2) != 0;
      guard++;
    end
    if (n_acc < target) begin
      errors++;
      checks++;
      $display("FAIL random_budget: got %0d beats expected %0d",
               n_acc, target);
    end
    cyc();
    drive(0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk("lit_drained", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
